// File: rtl/johnson_step_controller.sv
// Johnson (twisted-ring) step sequencer: accepts step commands over a
// valid/ready handshake and advances the ring up or down by the commanded
// number of steps, one step every (prescale+1) cycles, with a one-cycle
// completion pulse.
// Optional build macro JOHNSON_STEP_CHECK_EN adds an illegal-code checker
// driving a sticky err flag; without it err is tied low.
module johnson_step_controller #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_up_down,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_prescale,
    input  logic             abort,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic [DIV_W-1:0] tick_reg, tick_next;
    logic [DIV_W-1:0] prescale_reg, prescale_next;
    logic             up_down_reg, up_down_next;
    logic [WIDTH-1:0] stepped;
    logic             accept;

    assign accept = cmd_valid && cmd_ready;

    // One ring step in the latched direction.
    always_comb begin
        if (up_down_reg)
            stepped = {out_reg[WIDTH-2:0], ~out_reg[WIDTH-1]};
        else
            stepped = {~out_reg[0], out_reg[WIDTH-1:1]};
    end

`ifdef JOHNSON_STEP_CHECK_EN
    // A legal Johnson code has at most one boundary between adjacent bits
    // (ignoring the MSB-to-LSB wraparound).
    logic [WIDTH-2:0] diff;
    logic             illegal;
    logic             err_reg, err_next;

    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_diff
        assign diff[gi] = out_reg[gi] ^ out_reg[gi+1];
    end

    // More than one bit set in diff means more than one boundary.
    assign illegal = |(diff & (diff - 1'b1));
    assign err     = err_reg;
`else
    assign err = 1'b0;
`endif

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            out_reg       <= '0;
            remaining_reg <= '0;
            tick_reg      <= '0;
            prescale_reg  <= '0;
            up_down_reg   <= 1'b0;
`ifdef JOHNSON_STEP_CHECK_EN
            err_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            out_reg       <= out_next;
            remaining_reg <= remaining_next;
            tick_reg      <= tick_next;
            prescale_reg  <= prescale_next;
            up_down_reg   <= up_down_next;
`ifdef JOHNSON_STEP_CHECK_EN
            err_reg       <= err_next;
`endif
        end
    end

    // Next-state logic: command accept, prescaled stepping, abort.
    always_comb begin
        state_next     = state_reg;
        out_next       = out_reg;
        remaining_next = remaining_reg;
        tick_next      = tick_reg;
        prescale_next  = prescale_reg;
        up_down_next   = up_down_reg;
`ifdef JOHNSON_STEP_CHECK_EN
        err_next       = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    up_down_next   = cmd_up_down;
                    prescale_next  = cmd_prescale;
                    remaining_next = cmd_steps;
                    tick_next      = cmd_prescale;
                    state_next     = (cmd_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = DONE;
                end else if (tick_reg != '0) begin
                    tick_next = tick_reg - 1'b1;
                end else begin
                    out_next       = stepped;
                    tick_next      = prescale_reg;
                    // Saturate at zero so the count can never wrap.
                    remaining_next = (remaining_reg != '0) ? remaining_reg - 1'b1 : '0;
                    if (remaining_reg <= CNT_W'(1))
                        state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef JOHNSON_STEP_CHECK_EN
        // A corrupted code overrides everything: clear the ring, flag it,
        // and end any running command.
        if (illegal) begin
            out_next = '0;
            err_next = 1'b1;
            if (state_reg == RUN)
                state_next = DONE;
        end
`endif
    end

    // Outputs decoded from the current state.
    always_comb begin
        cmd_ready = (state_reg == IDLE) && !reset;
        busy      = (state_reg == RUN);
        done      = (state_reg == DONE);
        out       = out_reg;
    end

endmodule

// File: tb/tb_johnson_step_controller.sv
// Directed self-checking bench for johnson_step_controller (WIDTH=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_johnson_step_controller;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_up_down;
    logic [7:0] cmd_steps;
    logic [7:0] cmd_prescale;
    logic       abort;
    logic [3:0] out;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    johnson_step_controller #(.WIDTH(4), .CNT_W(8), .DIV_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_up_down  (cmd_up_down),
        .cmd_steps    (cmd_steps),
        .cmd_prescale (cmd_prescale),
        .abort        (abort),
        .out          (out),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Present one command for a single edge (the accept edge E0).
    task automatic send(input logic up, input logic [7:0] steps, input logic [7:0] pre);
        $display("cmd: up=%0d steps=%0d prescale=%0d start_out=%b", up, steps, pre, out);
        cmd_up_down  = up;
        cmd_steps    = steps;
        cmd_prescale = pre;
        cmd_valid    = 1'b1;
        tick();
        cmd_valid    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++; if (out !== 4'b0000) begin errors++; $display("FAIL reset_out: got %b want 0000", out); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b done=%b want 0 0", busy, done); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset: got %b want 0", cmd_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        reset = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", cmd_ready); end
    endtask

    task automatic test_up_run();
        logic [3:0] exp_seq [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110};
        send(1'b1, 8'd5, 8'd0);
        checks++; if (busy !== 1'b1 || out !== 4'b0000) begin errors++; $display("FAIL up_accept: busy=%b out=%b want 1 0000", busy, out); end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (out !== exp_seq[k]) begin errors++; $display("FAIL up_step%0d: got %b want %b", k + 1, out, exp_seq[k]); end
        end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL up_done: done=%b busy=%b want 1 0", done, busy); end
        tick();
        checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL up_idle: done=%b ready=%b want 0 1", done, cmd_ready); end
    endtask

    task automatic test_down_run();
        logic [3:0] exp_seq [3] = '{4'b1111, 4'b0111, 4'b0011};
        send(1'b0, 8'd3, 8'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (out !== exp_seq[k]) begin errors++; $display("FAIL down_step%0d: got %b want %b", k + 1, out, exp_seq[k]); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL down_done: got %b want 1", done); end
        tick();
    endtask

    task automatic test_prescale();
        logic [3:0] exp_seq [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0011};
        int busy_cnt;
        do_reset();
        busy_cnt = 0;
        send(1'b1, 8'd2, 8'd2);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            if (busy === 1'b1) busy_cnt++;
            checks++; if (out !== exp_seq[i]) begin errors++; $display("FAIL pre_out_e0+%0d: got %b want %b", i, out, exp_seq[i]); end
        end
        checks++; if (busy_cnt !== 6) begin errors++; $display("FAIL pre_busy_cycles: got %0d want 6", busy_cnt); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pre_done: got %b want 1", done); end
        tick();
    endtask

    task automatic test_zero_steps();
        send(1'b1, 8'd0, 8'd5);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done: done=%b busy=%b want 1 0", done, busy); end
        checks++; if (out !== 4'b0011) begin errors++; $display("FAIL zero_out: got %b want 0011", out); end
        tick();
        checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zero_idle: ready=%b done=%b want 1 0", cmd_ready, done); end
    endtask

    task automatic test_wrap();
        send(1'b1, 8'd8, 8'd0);
        for (int k = 0; k < 8; k++) tick();
        checks++; if (out !== 4'b0011 || done !== 1'b1) begin errors++; $display("FAIL wrap: out=%b done=%b want 0011 1", out, done); end
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        send(1'b1, 8'd10, 8'd1);
        for (int k = 0; k < 6; k++) tick();
        checks++; if (out !== 4'b0111) begin errors++; $display("FAIL abort_pre: got %b want 0111", out); end
        tick();
        // Abort on the edge where the fourth step would otherwise land.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (done !== 1'b1 || out !== 4'b0111) begin errors++; $display("FAIL abort_done: done=%b out=%b want 1 0111", done, out); end
        tick();
        checks++; if (cmd_ready !== 1'b1 || out !== 4'b0111) begin errors++; $display("FAIL abort_idle: ready=%b out=%b want 1 0111", cmd_ready, out); end
    endtask

    task automatic test_reset_mid_run();
        send(1'b1, 8'd10, 8'd1);
        tick();
        tick();
        checks++; if (out !== 4'b1111 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre: out=%b busy=%b want 1111 1", out, busy); end
        reset = 1'b1;
        tick();
        checks++; if (out !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst: out=%b busy=%b done=%b want 0000 0 0", out, busy, done); end
        reset = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", cmd_ready); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_nodone: got %b want 0", done); end
    endtask

    task automatic test_back_to_back();
        send(1'b1, 8'd1, 8'd0);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_run: got %b want 0", cmd_ready); end
        tick();
        checks++; if (out !== 4'b0001 || done !== 1'b1) begin errors++; $display("FAIL b2b_first: out=%b done=%b want 0001 1", out, done); end
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", cmd_ready); end
        send(1'b0, 8'd1, 8'd0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: busy=%b want 1", busy); end
        tick();
        checks++; if (out !== 4'b0000 || done !== 1'b1) begin errors++; $display("FAIL b2b_second: out=%b done=%b want 0000 1", out, done); end
        tick();
    endtask

    task automatic test_ignore();
        send(1'b1, 8'd2, 8'd0);
        // Keep a conflicting command pending while the first one runs.
        cmd_valid   = 1'b1;
        cmd_up_down = 1'b0;
        cmd_steps   = 8'd0;
        tick();
        checks++; if (out !== 4'b0001 || done !== 1'b0) begin errors++; $display("FAIL ign_step1: out=%b done=%b want 0001 0", out, done); end
        tick();
        checks++; if (out !== 4'b0011 || done !== 1'b1) begin errors++; $display("FAIL ign_step2: out=%b done=%b want 0011 1", out, done); end
        tick();
        cmd_valid = 1'b0;
        checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL ign_idle: done=%b ready=%b want 0 1", done, cmd_ready); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (cmd_ready !== 1'b1 || done !== 1'b0 || out !== 4'b0011) begin errors++; $display("FAIL ign_abort_idle: ready=%b done=%b out=%b want 1 0 0011", cmd_ready, done, out); end
    endtask

    task automatic test_checker();
`ifdef JOHNSON_STEP_CHECK_EN
        do_reset();
        send(1'b1, 8'd10, 8'd1);
        force dut.out_reg = 4'b0101;
        #1;
        release dut.out_reg;
        tick();
        checks++; if (out !== 4'b0000 || err !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL chk_trip: out=%b err=%b done=%b want 0000 1 1", out, err, done); end
        tick();
        tick();
        checks++; if (err !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL chk_sticky: err=%b ready=%b want 1 1", err, cmd_ready); end
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk_clear: got %b want 0", err); end
`else
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_tied: got %b want 0", err); end
`endif
    endtask

    initial begin
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_up_down  = 1'b0;
        cmd_steps    = '0;
        cmd_prescale = '0;
        abort        = 1'b0;
        tick();
        test_reset();
        test_up_run();
        test_down_run();
        test_prescale();
        test_zero_steps();
        test_wrap();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        test_ignore();
        test_checker();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/johnson_step_controller.md
# johnson_step_controller

Sequencer for a WIDTH-bit Johnson (twisted-ring) counter. It accepts step commands over a valid/ready handshake, then advances the ring up or down by a commanded number of steps at a programmable rate. It reports completion with a one-cycle pulse. It sits between a command source (host register block or motion FSM) and any logic that consumes the Johnson-coded phase outputs.

## Interface
- `WIDTH`, default 4: Johnson ring width; sequence period is 2*WIDTH.
- `CNT_W`, default 8: width of the step-count field.
- `DIV_W`, default 8: width of the prescale field.

- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_up_down` in 1: 1 = step up, 0 = step down.
- `cmd_steps` in CNT_W: number of steps to perform (0 allowed).
- `cmd_prescale` in DIV_W: idle cycles between steps; step period = cmd_prescale+1.
- `abort` in 1: terminate the running command.
- `out` out WIDTH: Johnson code.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky illegal-code flag (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- Reset (any state): state←IDLE, `out`←0, remaining←0, tick←0, `busy`=0, `done`=0, `err`←0.
- `cmd_ready` = (state==IDLE) && !reset.
- Accept: rising edge with `cmd_valid` && `cmd_ready`.
  - Latch direction and prescale; remaining←`cmd_steps`; tick←`cmd_prescale`.
  - If `cmd_steps`==0: go to DONE; no step occurs.
  - Otherwise: go to RUN.
- RUN, evaluated in this priority order:
  - `abort`=1: go to DONE; no step in that cycle.
  - tick≠0: tick←tick−1.
  - tick==0: perform one step; remaining←remaining−1; tick←prescale.
  - A step with remaining==1 goes to DONE.
- Step rule:
  - Up: `out`←{out[WIDTH-2:0], ~out[WIDTH-1]}.
  - Down: `out`←{~out[0], out[WIDTH-1:1]}.
- Wrap-around is inherent: 2*WIDTH steps in either direction return `out` to its start value. Count arithmetic is unsigned. Remaining never underflows.
- DONE: `done`=1 for exactly one cycle, then IDLE. `out` holds its value in IDLE and DONE.
- `abort` in IDLE or DONE is ignored. `cmd_valid` outside IDLE is ignored; the command is not queued.

## Timing
- Accept at edge E0. The k-th step (k≥1) updates `out` at edge E0 + k*(prescale+1).
- `done` is high in the cycle after the final step edge. `cmd_ready` rises one cycle after that.
- Minimum command turnaround with prescale=0 and N≥1 steps: N+2 cycles from accept to next accept.
- Zero-step command: `done` is high in the cycle after E0.
- Abort sampled at edge Ea: `done` is high in the cycle after Ea. `out` keeps its last stepped value.
- Reset mid-RUN takes effect at the next edge. No `done` pulse is produced; `out` returns to 0.

## Configuration
- Macro: `JOHNSON_STEP_CHECK_EN`.
- Defined:
  - Every cycle, `out` is checked for a legal Johnson code: at most one bit change between adjacent positions out[i], out[i+1], excluding the wraparound.
  - On an illegal code, at the next edge: `out`←0 and `err`←1, sticky until reset.
  - If in RUN, go to DONE. This takes priority over `abort` and stepping.
- Undefined: no checker logic. `err` is tied to 0.

## Test plan
- Reset, WIDTH=4. Command up, steps=5, prescale=0. Required `out` sequence: 0001, 0011, 0111, 1111, 1110 on consecutive edges, then a one-cycle `done`, then `cmd_ready`=1.
- From `out`=1110, command down, steps=3, prescale=0 → `out` 1111, 0111, 0011, `done` pulse.
- Command up, steps=2, prescale=2 → steps at edges E0+3 and E0+6; `busy` high for 6 cycles; `out` 0000→0001→0011.
- Command steps=0 → `done` in the cycle after accept; `out` unchanged; `busy` never high. Command up, steps=8 → `out` returns to its start value.
- Command up, steps=10, prescale=1, `abort` pulsed after 3 steps → no further step; `done` next cycle; `out`=0111. Repeat the command and assert `reset` mid-RUN → `out`=0000 and IDLE at the next edge, with no `done` pulse.
- With `JOHNSON_STEP_CHECK_EN`: force `out` to 0101 during RUN → next edge `out`=0000, `err`=1, `done` pulse; `err` stays 1 until reset. Without the macro, `err` stays 0 throughout.
